// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run/halt/single-step sequencer for sm_cpu plus a register dump
// walker that streams the register file over a valid/ready port while halted.
// Optional breakpoint comparator: define SM_RUN_CTRL_BREAKPOINT_EN.
module sm_run_ctrl #(
    parameter bit          RESET_RUN = 1'b1,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_run,
    input  logic        cmd_halt,
    input  logic        cmd_step,
    input  logic        cmd_dump,
    input  logic [31:0] cpu_pc,
    output logic        cpu_en,
    input  logic [4:0]  host_reg_addr,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_done,
    output logic        halted
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    ,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        bp_hit
`endif
);

    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] HALT    = 3'd1;
    localparam logic [2:0] STEP    = 3'd2;
    localparam logic [2:0] DUMP_RD = 3'd3;
    localparam logic [2:0] DUMP_TX = 3'd4;

    localparam logic [2:0] RESET_STATE = RESET_RUN ? RUN : HALT;
    localparam logic [4:0] LAST_IDX    = 5'(NUM_REGS - 1);

    logic [2:0] state;
    logic [2:0] stateNext;
    logic [4:0] idx;
    logic       cpuEnReg;
    logic       bpMatch;
    logic       lastAccept;

    assign lastAccept = (state == DUMP_TX) && dump_ready && (idx == LAST_IDX);

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    logic resumed;

    // Breakpoint compare, masked in the first RUN cycle after a resume
    assign bpMatch = (state == RUN) && !resumed && bp_en && (cpu_pc == bp_addr);

    // Resume marker and sticky hit flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resumed <= 1'b0;
            bp_hit  <= 1'b0;
        end else begin
            resumed <= (state == HALT) && (stateNext == RUN);
            if (bpMatch)
                bp_hit <= 1'b1;
            else if ((state == HALT) && ((stateNext == RUN) || (stateNext == STEP)))
                bp_hit <= 1'b0;
        end
    end
`else
    assign bpMatch = 1'b0;
`endif

    // Next-state selection; command priority halt > step > run > dump
    always_comb begin
        stateNext = state;
        case (state)
            RUN: begin
                if (bpMatch || cmd_halt)
                    stateNext = HALT;
                else if (cmd_step)
                    stateNext = STEP;
            end
            HALT: begin
                if (cmd_halt)
                    stateNext = HALT;
                else if (cmd_step)
                    stateNext = STEP;
                else if (cmd_run)
                    stateNext = RUN;
                else if (cmd_dump)
                    stateNext = DUMP_RD;
            end
            STEP:    stateNext = HALT;
            DUMP_RD: stateNext = DUMP_TX;
            DUMP_TX: begin
                if (dump_ready)
                    stateNext = (idx == LAST_IDX) ? HALT : DUMP_RD;
            end
            default: stateNext = HALT;
        endcase
    end

    // State register and registered clock enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_STATE;
            cpuEnReg <= RESET_RUN;
        end else begin
            state    <= stateNext;
            cpuEnReg <= (stateNext == RUN) || (stateNext == STEP);
        end
    end

    // Dump walker: index, captured beat and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            dump_addr <= '0;
            dump_data <= '0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= lastAccept;
            if ((state == HALT) && (stateNext == DUMP_RD))
                idx <= '0;
            else if ((state == DUMP_TX) && dump_ready && (idx != LAST_IDX))
                idx <= idx + 5'd1;
            if (state == DUMP_RD) begin
                dump_data <= reg_data;
                dump_addr <= idx;
            end
        end
    end

    // A breakpoint hit gates the enable in the same cycle so the instruction is not executed
    assign cpu_en     = cpuEnReg & ~bpMatch;
    assign dump_valid = (state == DUMP_TX);
    assign reg_addr   = ((state == DUMP_RD) || (state == DUMP_TX)) ? idx : host_reg_addr;
    assign halted     = (state != RUN) && (state != STEP);

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl: directed vector table, hand sequences for
// the multi-cycle cases, and a randomized phase against a behavioural model.
`timescale 1ns/1ps
module tb_sm_run_ctrl;

    localparam int unsigned NREGS = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmdRun = 1'b0, cmdHalt = 1'b0, cmdStep = 1'b0, cmdDump = 1'b0;
    logic        dumpReady = 1'b0;
    logic [31:0] cpuPc;
    logic        cpuEn;
    logic [4:0]  hostRegAddr = '0;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        dumpValid, dumpDone, halted;
    logic [4:0]  dumpAddr;
    logic [31:0] dumpData;
    logic [31:0] regs [NREGS];
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    logic        bpEn = 1'b0;
    logic [31:0] bpAddr = '0;
    logic        bpHit;
`endif

    int unsigned nVec = 0;
    int unsigned nMis = 0;

    sm_run_ctrl #(.RESET_RUN(1'b1), .NUM_REGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .cmd_run(cmdRun), .cmd_halt(cmdHalt), .cmd_step(cmdStep), .cmd_dump(cmdDump),
        .cpu_pc(cpuPc), .cpu_en(cpuEn),
        .host_reg_addr(hostRegAddr), .reg_addr(regAddr), .reg_data(regData),
        .dump_valid(dumpValid), .dump_ready(dumpReady),
        .dump_addr(dumpAddr), .dump_data(dumpData), .dump_done(dumpDone),
        .halted(halted)
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        , .bp_en(bpEn), .bp_addr(bpAddr), .bp_hit(bpHit)
`endif
    );

    always #5 clk = ~clk;

    // Minimal CPU stand-in: pc advances by 4 per enabled clock, combinational register read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cpuPc <= '0;
        else if (cpuEn) cpuPc <= cpuPc + 32'd4;
    end
    assign regData = regs[regAddr];

    // ---------------- behavioural reference model ----------------
    bit          mRun, mStep, mDumping, mLoaded, mDone, mResumed, mBpHit;
    int unsigned mBeat;
    logic [4:0]  mLastAddr;
    logic [31:0] mLastData, mPc;

    function automatic bit mBpMatch();
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        return mRun && !mResumed && bpEn && (mPc == bpAddr);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit mEn();
        return (mRun && !mBpMatch()) || mStep;
    endfunction

    task automatic modelReset();
        mRun = 1'b1; mStep = 1'b0; mDumping = 1'b0; mLoaded = 1'b0; mDone = 1'b0;
        mResumed = 1'b0; mBpHit = 1'b0; mBeat = 0;
        mLastAddr = '0; mLastData = '0; mPc = '0;
    endtask

    task automatic modelClock();
        bit en;
        bit bp;
        en = mEn();
        bp = mBpMatch();
        mDone = 1'b0;
        if (mDumping) begin
            if (!mLoaded) begin
                mLastAddr = 5'(mBeat);
                mLastData = regs[mBeat];
                mLoaded   = 1'b1;
            end else if (dumpReady) begin
                mLoaded = 1'b0;
                if (mBeat == NREGS - 1) begin
                    mDumping = 1'b0;
                    mDone    = 1'b1;
                end else begin
                    mBeat++;
                end
            end
        end else if (mStep) begin
            mStep = 1'b0;
        end else if (mRun) begin
            mResumed = 1'b0;
            if (bp) begin
                mRun = 1'b0; mBpHit = 1'b1;
            end else if (cmdHalt) begin
                mRun = 1'b0;
            end else if (cmdStep) begin
                mRun = 1'b0; mStep = 1'b1;
            end
        end else begin
            if (cmdHalt) begin
                // stays halted
            end else if (cmdStep) begin
                mStep = 1'b1; mBpHit = 1'b0;
            end else if (cmdRun) begin
                mRun = 1'b1; mResumed = 1'b1; mBpHit = 1'b0;
            end else if (cmdDump) begin
                mDumping = 1'b1; mBeat = 0; mLoaded = 1'b0;
            end
        end
        if (en) mPc = mPc + 32'd4;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll();
        chk("cpu_en", 32'(cpuEn), 32'(mEn()));
        chk("halted", 32'(halted), 32'(!(mRun || mStep)));
        chk("dump_valid", 32'(dumpValid), 32'(mDumping && mLoaded));
        chk("dump_done", 32'(dumpDone), 32'(mDone));
        chk("reg_addr", 32'(regAddr), mDumping ? 32'(mBeat) : 32'(hostRegAddr));
        chk("dump_addr", 32'(dumpAddr), 32'(mLastAddr));
        chk("dump_data", dumpData, mLastData);
        chk("cpu_pc", cpuPc, mPc);
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        chk("bp_hit", 32'(bpHit), 32'(mBpHit));
`endif
    endtask

    // Inputs are driven at the falling edge; one call = one rising edge then a check
    task automatic cycle();
        @(posedge clk);
        modelClock();
        @(negedge clk);
        checkAll();
    endtask

    task automatic doReset();
        cmdRun = 1'b0; cmdHalt = 1'b0; cmdStep = 1'b0; cmdDump = 1'b0;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAll();
    endtask

    function automatic logic [31:0] expReg(input int unsigned n);
        return (n == 0) ? 32'h0 : 32'h10 + 32'(n);
    endfunction

    typedef struct {
        bit run, halt, step, dump;
        bit en, hlt, vld;
    } vec_t;

    vec_t tbl [12];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] saved;
        logic [4:0]  heldAddr;
        logic [31:0] heldData;
        bit          holdChk;
        int unsigned beat, dones, guard;

        for (int i = 0; i < NREGS; i++) regs[i] = expReg(i);

        tbl[0]  = '{run:0, halt:0, step:0, dump:0, en:1, hlt:0, vld:0};
        tbl[1]  = '{run:0, halt:1, step:0, dump:0, en:0, hlt:1, vld:0};
        tbl[2]  = '{run:0, halt:0, step:0, dump:0, en:0, hlt:1, vld:0};
        tbl[3]  = '{run:1, halt:1, step:0, dump:0, en:0, hlt:1, vld:0};
        tbl[4]  = '{run:1, halt:0, step:1, dump:0, en:1, hlt:0, vld:0};
        tbl[5]  = '{run:0, halt:0, step:0, dump:0, en:0, hlt:1, vld:0};
        tbl[6]  = '{run:1, halt:0, step:0, dump:1, en:1, hlt:0, vld:0};
        tbl[7]  = '{run:0, halt:0, step:1, dump:0, en:1, hlt:0, vld:0};
        tbl[8]  = '{run:1, halt:0, step:0, dump:0, en:0, hlt:1, vld:0};
        tbl[9]  = '{run:0, halt:0, step:0, dump:1, en:0, hlt:1, vld:0};
        tbl[10] = '{run:1, halt:1, step:1, dump:0, en:0, hlt:1, vld:1};
        tbl[11] = '{run:0, halt:0, step:0, dump:0, en:0, hlt:1, vld:1};

        // Reset, then free-running after release
        modelReset();
        @(negedge clk);
        doReset();
        repeat (5) cycle();
        chk("run_pc", cpuPc, 32'd20);

        // Directed command table (dump_ready held low)
        dumpReady = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cmdRun = tbl[i].run; cmdHalt = tbl[i].halt; cmdStep = tbl[i].step; cmdDump = tbl[i].dump;
            cycle();
            chk("tbl_en", 32'(cpuEn), 32'(tbl[i].en));
            chk("tbl_halted", 32'(halted), 32'(tbl[i].hlt));
            chk("tbl_valid", 32'(dumpValid), 32'(tbl[i].vld));
        end
        cmdRun = 1'b0; cmdHalt = 1'b0; cmdStep = 1'b0; cmdDump = 1'b0;

        // Continue the dump with dump_ready toggling; beats must hold while not accepted
        beat = 0; guard = 0; holdChk = 1'b0;
        heldAddr = '0; heldData = '0;
        while (!dumpDone && guard < 400) begin
            if (holdChk && dumpValid) begin
                chk("hold_addr", 32'(dumpAddr), 32'(heldAddr));
                chk("hold_data", dumpData, heldData);
            end
            dumpReady = ~dumpReady;
            holdChk = dumpValid && !dumpReady;
            heldAddr = dumpAddr; heldData = dumpData;
            if (dumpValid && dumpReady) begin
                chk("beat_addr", 32'(dumpAddr), beat);
                chk("beat_data", dumpData, expReg(beat));
                beat++;
            end
            cycle();
            guard++;
        end
        chk("dump_done_seen", 32'(dumpDone), 32'd1);
        chk("dump_beats", beat, NREGS);
        dones = 1;
        hostRegAddr = 5'd7;
        repeat (4) begin
            cycle();
            if (dumpDone) dones++;
        end
        chk("dump_done_once", dones, 32'd1);
        chk("host_port_back", 32'(regAddr), 32'd7);
        chk("halted_after_dump", 32'(halted), 32'd1);

        // Halted pc stays frozen; a step advances it by exactly one instruction
        saved = cpuPc;
        repeat (10) cycle();
        chk("pc_frozen", cpuPc, saved);
        cmdStep = 1'b1; cycle(); cmdStep = 1'b0;
        repeat (3) cycle();
        chk("pc_step", cpuPc, saved + 32'd4);
        chk("halted_after_step", 32'(halted), 32'd1);

        // cmd_run during a dump is ignored; dump completes and leaves the CPU halted
        dumpReady = 1'b1;
        cmdDump = 1'b1; cycle(); cmdDump = 1'b0;
        repeat (3) cycle();
        cmdRun = 1'b1; cycle(); cmdRun = 1'b0;
        guard = 0;
        while (!dumpDone && guard < 200) begin cycle(); guard++; end
        chk("dump2_done", 32'(dumpDone), 32'd1);
        cycle();
        chk("dump2_halted", 32'(halted), 32'd1);

        // Reset at beat 5 abandons the dump with no completion pulse
        cmdDump = 1'b1; cycle(); cmdDump = 1'b0;
        guard = 0;
        while (!(dumpValid && dumpAddr == 5'd5) && guard < 100) begin cycle(); guard++; end
        chk("reach_beat5", 32'(dumpAddr), 32'd5);
        rst = 1'b1;
        #1;
        chk("rst_valid_low", 32'(dumpValid), 32'd0);
        doReset();
        dones = 0;
        repeat (80) begin
            cycle();
            if (dumpDone) dones++;
        end
        chk("rst_no_done", dones, 32'd0);

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        // Breakpoint halts before executing bp_addr; resume executes through it
        doReset();
        bpEn = 1'b1; bpAddr = 32'h10;
        guard = 0;
        while (!halted && guard < 40) begin cycle(); guard++; end
        repeat (3) cycle();
        chk("bp_pc", cpuPc, 32'h10);
        chk("bp_hit_set", 32'(bpHit), 32'd1);
        cmdRun = 1'b1; cycle(); cmdRun = 1'b0;
        repeat (3) cycle();
        chk("bp_passed", 32'(cpuPc > 32'h10), 32'd1);
        chk("bp_hit_clr", 32'(bpHit), 32'd0);
        bpEn = 1'b0;
`endif

        // Randomized phase against the model
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        doReset();
        for (int n = 0; n < 3000; n++) begin
            cmdHalt   = ($urandom_range(0, 9) == 0);
            cmdStep   = ($urandom_range(0, 9) == 0);
            cmdRun    = ($urandom_range(0, 7) == 0);
            cmdDump   = ($urandom_range(0, 5) == 0);
            dumpReady = $urandom_range(0, 1) == 1;
            hostRegAddr = 5'($urandom);
            if ($urandom_range(0, 499) == 0) doReset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
